// File: rtl/sobel_window_fetch_if.sv
// Pixel-stream, dual-port RAM and window-output signals of the Sobel window fetcher.
// The master modport is the fetch controller; the slave modport is its environment.
interface sobel_window_fetch_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
);
  logic                    s_valid;
  logic                    s_ready;
  logic [DATA_WIDTH-1:0]   s_data;

  logic [ADDR_WIDTH-1:0]   addr0;
  logic                    ce0;
  logic                    we0;
  logic [DATA_WIDTH-1:0]   d0;
  logic [DATA_WIDTH-1:0]   q0;

  logic [ADDR_WIDTH-1:0]   addr1;
  logic                    ce1;
  logic                    we1;
  logic [DATA_WIDTH-1:0]   d1;
  logic [DATA_WIDTH-1:0]   q1;

  logic                    w_valid;
  logic                    w_ready;
  logic [9*DATA_WIDTH-1:0] w_data;
  logic [ADDR_WIDTH-1:0]   w_x;
  logic [ADDR_WIDTH-1:0]   w_y;

  modport master (
    input  s_valid, s_data, q0, q1, w_ready,
    output s_ready, addr0, ce0, we0, d0, addr1, ce1, we1, d1,
           w_valid, w_data, w_x, w_y
  );

  modport slave (
    output s_valid, s_data, q0, q1, w_ready,
    input  s_ready, addr0, ce0, we0, d0, addr1, ce1, we1, d1,
           w_valid, w_data, w_x, w_y
  );
endinterface

// File: rtl/sobel_window_fetch.sv
// Loads one frame into a dual-port RAM, then fetches every interior 3x3
// neighbourhood in raster order and hands it out over valid/ready.
module sobel_window_fetch #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12,
  parameter int IMG_W      = 64,
  parameter int IMG_H      = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
  sobel_window_fetch_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FETCH = 3'd2,
    S_OUT   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(IMG_W * IMG_H - 1);
  localparam logic [ADDR_WIDTH-1:0] X_LAST   = ADDR_WIDTH'(IMG_W - 2);
  localparam logic [ADDR_WIDTH-1:0] Y_LAST   = ADDR_WIDTH'(IMG_H - 2);

  // Offset of window slot k (k = 3*dy + dx) from the top-left address.
  function automatic logic [ADDR_WIDTH-1:0] slot_off(input int k);
    return ADDR_WIDTH'((k / 3) * IMG_W + (k % 3));
  endfunction

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   load_cnt_reg;
  logic [ADDR_WIDTH-1:0]   x_reg, y_reg;
  logic [ADDR_WIDTH-1:0]   base_reg;
  logic [2:0]              f_reg;
  logic [ADDR_WIDTH-1:0]   w_x_reg, w_y_reg;
  logic                    w_valid_reg;
  logic                    busy_reg;
  logic                    done_reg;
  logic [9*DATA_WIDTH-1:0] w_data_w;

  logic                    s_fire;
  logic                    w_fire;
  logic                    last_win;
  logic [ADDR_WIDTH-1:0]   off_p0, off_p1;

  assign s_fire   = (state_reg == S_LOAD) && bus.s_valid;
  assign w_fire   = (state_reg == S_OUT) && bus.w_ready;
  assign last_win = (x_reg == X_LAST) && (y_reg == Y_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_LOAD;
      S_LOAD:  if (s_fire && (load_cnt_reg == LAST_PIX)) state_next = S_FETCH;
      S_FETCH: if (f_reg == 3'd5) state_next = S_OUT;
      S_OUT:   if (w_fire) state_next = last_win ? S_DONE : S_FETCH;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Two slots per cycle: port 0 takes the even slot, port 1 the odd one.
  always_comb begin
    off_p0 = '0;
    off_p1 = '0;
    case (f_reg)
      3'd0: begin off_p0 = slot_off(0); off_p1 = slot_off(1); end
      3'd1: begin off_p0 = slot_off(2); off_p1 = slot_off(3); end
      3'd2: begin off_p0 = slot_off(4); off_p1 = slot_off(5); end
      3'd3: begin off_p0 = slot_off(6); off_p1 = slot_off(7); end
      3'd4: begin off_p0 = slot_off(8); off_p1 = '0;          end
      default: begin off_p0 = '0; off_p1 = '0; end
    endcase
  end

  always_comb begin
    bus.s_ready = (state_reg == S_LOAD);
    bus.addr0   = '0;
    bus.ce0     = 1'b0;
    bus.we0     = 1'b0;
    bus.d0      = '0;
    bus.addr1   = '0;
    bus.ce1     = 1'b0;
    bus.we1     = 1'b0;
    bus.d1      = '0;
    case (state_reg)
      S_LOAD: begin
        bus.addr0 = load_cnt_reg;
        if (bus.s_valid) begin
          bus.ce0 = 1'b1;
          bus.we0 = 1'b1;
          bus.d0  = bus.s_data;
        end
      end
      S_FETCH: begin
        if (f_reg <= 3'd4) begin
          bus.ce0   = 1'b1;
          bus.addr0 = base_reg + off_p0;
        end
        if (f_reg <= 3'd3) begin
          bus.ce1   = 1'b1;
          bus.addr1 = base_reg + off_p1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      load_cnt_reg <= '0;
      x_reg        <= '0;
      y_reg        <= '0;
      base_reg     <= '0;
      f_reg        <= '0;
      w_x_reg      <= '0;
      w_y_reg      <= '0;
      w_valid_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      busy_reg    <= (state_next != S_IDLE);
      done_reg    <= (state_next == S_DONE);
      w_valid_reg <= (state_next == S_OUT);
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            load_cnt_reg <= '0;
            x_reg        <= ADDR_WIDTH'(1);
            y_reg        <= ADDR_WIDTH'(1);
            base_reg     <= '0;
            f_reg        <= '0;
          end
        end
        S_LOAD: begin
          if (s_fire) load_cnt_reg <= load_cnt_reg + ADDR_WIDTH'(1);
        end
        S_FETCH: begin
          f_reg <= (f_reg == 3'd5) ? 3'd0 : f_reg + 3'd1;
          if (f_reg == 3'd5) begin
            w_x_reg <= x_reg;
            w_y_reg <= y_reg;
          end
        end
        S_OUT: begin
          if (w_fire) begin
            f_reg <= '0;
            // Top-left moves one pixel right, or skips the two border columns on wrap.
            if (x_reg == X_LAST) begin
              x_reg    <= ADDR_WIDTH'(1);
              y_reg    <= y_reg + ADDR_WIDTH'(1);
              base_reg <= base_reg + ADDR_WIDTH'(3);
            end else begin
              x_reg    <= x_reg + ADDR_WIDTH'(1);
              base_reg <= base_reg + ADDR_WIDTH'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Slot gi returns on the cycle after its read was issued in cycle gi/2.
  for (genvar gi = 0; gi < 9; gi++) begin : g_slot
    localparam logic [2:0] CAP_F   = 3'(gi / 2 + 1);
    localparam bit         FROM_Q1 = (gi % 2) == 1;
    logic [DATA_WIDTH-1:0] slot_reg;

    always_ff @(posedge clk) begin
      if (reset) begin
        slot_reg <= '0;
      end else if ((state_reg == S_FETCH) && (f_reg == CAP_F)) begin
        slot_reg <= FROM_Q1 ? bus.q1 : bus.q0;
      end
    end

    assign w_data_w[gi*DATA_WIDTH +: DATA_WIDTH] = slot_reg;
  end

  assign bus.w_valid = w_valid_reg;
  assign bus.w_data  = w_data_w;
  assign bus.w_x     = w_x_reg;
  assign bus.w_y     = w_y_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;

endmodule

// File: doc/sobel_window_fetch.md
# sobel_window_fetch

Controller that sequences the team's dual-port block RAM for the Sobel edge detector. It loads one IMG_W×IMG_H greyscale frame from a valid/ready pixel stream into the RAM, then scans every interior pixel in raster order. For each one it fetches the 3×3 neighbourhood using both RAM ports and presents the window to the Sobel kernel over a valid/ready handshake.

## Interface

Parameters:

- DATA_WIDTH, 8: pixel width; must match the RAM.
- ADDR_WIDTH, 12: RAM address width.
- IMG_W, 64: frame width in pixels. Must be ≥ 3.
- IMG_H, 64: frame height in pixels. Must be ≥ 3, and IMG_W×IMG_H ≤ 2^ADDR_WIDTH.

Ports (clock and reset):

- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.

Ports (control):

- start  in  1  one-cycle request to begin load+scan. Honoured only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last window is accepted.

Ports (pixel input stream):

- s_valid  in  1  input pixel valid.
- s_ready  out  1  block accepts a pixel.
- s_data  in  DATA_WIDTH  raster-order pixel.

Ports (RAM port 0):

- addr0  out  ADDR_WIDTH  address.
- ce0  out  1  chip enable.
- we0  out  1  write enable.
- d0  out  DATA_WIDTH  write data.
- q0  in  DATA_WIDTH  read data, one cycle after the read is issued.

Ports (RAM port 1):

- addr1  out  ADDR_WIDTH  address.
- ce1  out  1  chip enable.
- we1  out  1  write enable; tied 0.
- d1  out  DATA_WIDTH  write data; tied 0.
- q1  in  DATA_WIDTH  read data, one cycle after the read is issued.

Ports (window output):

- w_valid  out  1  window valid.
- w_ready  in  1  downstream accepts the window.
- w_data  out  9×DATA_WIDTH  window; slot k at bits [k×DATA_WIDTH +: DATA_WIDTH]. k = 3·dy+dx; slot 0 is top-left, slot 8 is bottom-right.
- w_x  out  ADDR_WIDTH  centre column.
- w_y  out  ADDR_WIDTH  centre row.

## Operation

States: IDLE, LOAD, FETCH, OUT, DONE.

- **IDLE**
  - All RAM controls are 0; s_ready is 0.
  - start=1 → LOAD; the load counter and centre (x,y) are cleared to 0 and (1,1).
- **LOAD**
  - s_ready=1.
  - On each handshake (s_valid&s_ready): ce0=we0=1, addr0=load count, d0=s_data, and the count increments.
  - When the handshake on pixel IMG_W×IMG_H−1 completes → FETCH.
- **FETCH**
  - Six-cycle sub-counter f = 0..5. Base address b = (y−1)·IMG_W + (x−1).
  - Cycles f=0..3: port 0 reads slot 2f and port 1 reads slot 2f+1.
  - Cycle f=4: port 0 only reads slot 8; ce1=0.
  - Slot address = b + dy·IMG_W + dx. All reads use we=0.
  - Cycles f=1..5 capture q0/q1 into the slots issued in cycle f−1.
  - After f=5 → OUT.
- **OUT**
  - w_valid=1. w_data, w_x and w_y are held stable; no RAM access.
  - When w_ready=1: advance x. At x=IMG_W−2, wrap x to 1 and increment y.
  - If the accepted window was (IMG_W−2, IMG_H−2) → DONE; otherwise → FETCH with f=0.
- **DONE**
  - done=1 for one cycle → IDLE.
- **Frame scope**
  - Windows emitted per frame = (IMG_W−2)×(IMG_H−2). Border pixels are never centres.
- **Address arithmetic**
  - Address arithmetic is ADDR_WIDTH unsigned and cannot overflow under the parameter constraints.
- **Ignored inputs**
  - start outside IDLE is ignored.
  - s_valid outside LOAD is ignored; s_ready is 0 there.

## Timing

- **Reset values** (state = IDLE): busy, done, s_ready, w_valid, ce0, we0, ce1, we1 = 0; addr0, addr1, d0, d1, w_data, w_x, w_y = 0. RAM contents are not cleared.
- **Output registration**
  - RAM controls and s_ready are combinational from the state registers and s_valid/s_data.
  - w_*, busy and done are registered.
- **Start/load:** start sampled in cycle t → LOAD in t+1; s_ready=1 from t+1.
- **Load duration:** one pixel per cycle when s_valid is held high. FETCH begins the cycle after the last handshake.
- **Window throughput:** 6 FETCH cycles plus 1 OUT cycle minimum, i.e. one window per 7 cycles with w_ready=1.
- **Backpressure:** w_ready low extends OUT indefinitely with no state change.
- **End of frame:** done asserts the cycle after the final OUT handshake; busy drops the following cycle.
- **Reset precedence:** reset in any state (including mid-FETCH with reads in flight) → IDLE next cycle with reset values. Late q0/q1 are ignored. Reset has priority over start.

## Test plan

Tests use IMG_W=IMG_H=4, pixel value = raster index.

- **Continuous load:** start, then 16 pixels with s_valid held high → 16 writes at addr0 0..15 on consecutive cycles; FETCH addr0/addr1 pairs (0,1),(2,4),(5,6),(8,9),(10,–).
- **Full scan, w_ready=1:** windows in order with w_data slots as below, 7 cycles apart; done pulses exactly once; busy=0 afterwards.
  - (1,1) = {0,1,2,4,5,6,8,9,10}
  - (2,1) = {1,2,3,5,6,7,9,10,11}
  - (1,2) = {4,5,6,8,9,10,12,13,14}
  - (2,2) = {5,6,7,9,10,11,13,14,15}
- **Backpressure:** hold w_ready=0 for 5 cycles on window (2,1) → w_valid, w_data and w_x/w_y stable; ce0=ce1=0 throughout; next window follows the handshake correctly.
- **Gapped input:** s_valid alternates 1/0 during LOAD → exactly 16 writes at correct addresses; scan output identical to the continuous-load scenario.
- **Reset mid-FETCH:** assert reset at f=2 of window (1,2) → next cycle all outputs at reset values. A new start plus reload reproduces the full window sequence.
- **start while busy, and minimum frame:**
  - start pulsed during LOAD and during OUT → no effect.
  - IMG_W=IMG_H=3 → single window (1,1) = {0..8}, then done.
